// File: rtl/arb_mux.sv
// arb_mux: N-channel round-robin arbitrating mux with a single registered output stage
// and valid/ready handshakes. Define ARB_MUX_LOCK_EN to build grant locking.
module arb_mux #(
  parameter int N = 2,
  parameter int W = 32,
  localparam int SW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_lock,
  output logic [N-1:0]   in_ready,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [SW-1:0]  out_sel
);

  logic          load_en;
  logic [N-1:0]  eligible;
  logic          found;
  logic [SW-1:0] grant;
  logic [W-1:0]  grant_data;
  logic [SW-1:0] last;

  assign load_en = !out_valid || out_ready;

`ifdef ARB_MUX_LOCK_EN
  logic          locked;
  logic [SW-1:0] lock_ch;
  logic          grant_lock;

  // While locked, only the owning channel may compete, even when it is idle.
  always_comb begin
    eligible = '0;
    for (int i = 0; i < N; i++) begin
      if (!locked || SW'(i) == lock_ch) begin
        eligible[i] = in_valid[i];
      end
    end
  end

  always_comb begin
    grant_lock = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == grant) begin
        grant_lock = in_lock[i];
      end
    end
  end

  // Every transferred beat decides whether its channel keeps the lock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      locked  <= 1'b0;
      lock_ch <= '0;
    end else if (load_en && found) begin
      locked  <= grant_lock;
      lock_ch <= grant;
    end
  end
`else
  logic unused_lock;

  assign eligible    = in_valid;
  assign unused_lock = ^in_lock;
`endif

  // Round-robin search starting one past the last granted channel, wrapping.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && eligible[i] && i == (int'(last) + k) % N) begin
          found = 1'b1;
          grant = SW'(i);
        end
      end
    end
  end

  always_comb begin
    grant_data = '0;
    in_ready   = '0;
    for (int i = 0; i < N; i++) begin
      if (SW'(i) == grant) begin
        grant_data  = in_data[i*W +: W];
        in_ready[i] = load_en && found;
      end
    end
  end

  // Output register reloads whenever it is empty or being drained this cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      last      <= SW'(N - 1);
    end else if (load_en) begin
      if (found) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_sel   <= grant;
        last      <= grant;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux.sv
// tb_arb_mux: directed, table-driven bench for a 4-channel, 8-bit arb_mux.
// Lock expectations follow ARB_MUX_LOCK_EN as defined for the build.
module tb_arb_mux;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] in_data;
  logic [N-1:0]   in_valid;
  logic [N-1:0]   in_lock;
  logic [N-1:0]   in_ready;
  logic [W-1:0]   out_data;
  logic           out_valid;
  logic           out_ready;
  logic [SW-1:0]  out_sel;

  int compared;
  int mismatched;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        ordy;
    logic [3:0]  exp_ready;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic [1:0]  exp_sel;
  } vec_t;

  vec_t vecs[16];

  logic [3:0] lock_ready[4];
  logic [7:0] lock_data[4];
  logic [1:0] lock_sel[4];

  arb_mux #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_lock   (in_lock),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sel   (out_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [3:0] valid, input logic [31:0] data,
                               input logic ordy, input logic [3:0] lock);
    in_valid  = valid;
    in_data   = data;
    out_ready = ordy;
    in_lock   = lock;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Round-robin, sparse request, backpressure and drain rows.
    vecs[0]  = '{4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[1]  = '{4'hF, 32'h44332211, 1'b1, 4'b0010, 1'b1, 8'h22, 2'd1};
    vecs[2]  = '{4'hF, 32'h44332211, 1'b1, 4'b0100, 1'b1, 8'h33, 2'd2};
    vecs[3]  = '{4'hF, 32'h44332211, 1'b1, 4'b1000, 1'b1, 8'h44, 2'd3};
    vecs[4]  = '{4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[5]  = '{4'h4, 32'h00A50000, 1'b1, 4'b0100, 1'b1, 8'hA5, 2'd2};
    vecs[6]  = '{4'h0, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'hA5, 2'd2};
    vecs[7]  = '{4'hF, 32'h44332211, 1'b0, 4'b1000, 1'b1, 8'h44, 2'd3};
    vecs[8]  = '{4'hF, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    vecs[9]  = '{4'hF, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    vecs[10] = '{4'hF, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    vecs[11] = '{4'hF, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    vecs[12] = '{4'hF, 32'h44332211, 1'b0, 4'b0000, 1'b1, 8'h44, 2'd3};
    vecs[13] = '{4'hF, 32'h44332211, 1'b1, 4'b0001, 1'b1, 8'h11, 2'd0};
    vecs[14] = '{4'h0, 32'h00000000, 1'b0, 4'b0000, 1'b1, 8'h11, 2'd0};
    vecs[15] = '{4'h0, 32'h00000000, 1'b1, 4'b0000, 1'b0, 8'h11, 2'd0};

`ifdef ARB_MUX_LOCK_EN
    lock_ready = '{4'b0001, 4'b0001, 4'b0001, 4'b0010};
    lock_data  = '{8'hA0, 8'hA1, 8'hA2, 8'hB1};
    lock_sel   = '{2'd0, 2'd0, 2'd0, 2'd1};
`else
    lock_ready = '{4'b0001, 4'b0010, 4'b0001, 4'b0010};
    lock_data  = '{8'hA0, 8'hB1, 8'hA2, 8'hB1};
    lock_sel   = '{2'd0, 2'd1, 2'd0, 2'd1};
`endif

    rst = 1'b0;
    applyStimulus(4'h0, 32'h0, 1'b0, 4'h0);
    #1 rst = 1'b1;
    #1;
    checkOutput("reset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("reset_out_data", {24'b0, out_data}, 32'd0);
    checkOutput("reset_out_sel", {30'b0, out_sel}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].ordy, 4'h0);
      #1;
      checkOutput($sformatf("vec%0d_in_ready", i), {28'b0, in_ready}, {28'b0, vecs[i].exp_ready});
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_valid});
      checkOutput($sformatf("vec%0d_out_data", i), {24'b0, out_data}, {24'b0, vecs[i].exp_data});
      checkOutput($sformatf("vec%0d_out_sel", i), {30'b0, out_sel}, {30'b0, vecs[i].exp_sel});
    end

    // Mid-stream reset: the held beat is dropped and channel 0 wins afterwards.
    applyStimulus(4'hF, 32'h44332211, 1'b1, 4'h0);
    @(posedge clk);
    #1;
    checkOutput("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    checkOutput("pre_reset_out_data", {24'b0, out_data}, 32'h22);
    rst = 1'b1;
    #1;
    checkOutput("midreset_out_valid", {31'b0, out_valid}, 32'd0);
    checkOutput("midreset_out_data", {24'b0, out_data}, 32'd0);
    checkOutput("midreset_out_sel", {30'b0, out_sel}, 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    applyStimulus(4'b0011, 32'h44332211, 1'b1, 4'h0);
    #1;
    checkOutput("postreset_in_ready", {28'b0, in_ready}, 32'b0001);
    @(posedge clk);
    #1;
    checkOutput("postreset_out_sel", {30'b0, out_sel}, 32'd0);
    checkOutput("postreset_out_data", {24'b0, out_data}, 32'h11);

    // Lock sequence: ch0 sends lock 1,1,0 while ch1 stays valid.
    rst = 1'b1;
    #1 rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus({2'b00, 1'b1, (c < 3)}, {8'h00, 8'h00, 8'hB1, 8'hA0 + 8'(c)}, 1'b1,
                    {3'b000, (c < 2)});
      #1;
      checkOutput($sformatf("lock%0d_in_ready", c), {28'b0, in_ready}, {28'b0, lock_ready[c]});
      @(posedge clk);
      #1;
      checkOutput($sformatf("lock%0d_out_sel", c), {30'b0, out_sel}, {30'b0, lock_sel[c]});
      checkOutput($sformatf("lock%0d_out_data", c), {24'b0, out_data}, {24'b0, lock_data[c]});
    end

    applyStimulus(4'h0, 32'h0, 1'b1, 4'h0);
    @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/arb_mux.md
# arb_mux

Parametrised N-channel, W-bit arbitrating multiplexer with a registered output and valid/ready handshakes on every channel. Successor to the combinational 2:1 select mux. Merges several requesters onto one downstream consumer, e.g. instruction fetch and load/store onto a single memory port in the multi-cycle/pipelined core. Selection is by a round-robin arbiter rather than an external select. Optional grant locking keeps multi-beat transfers unbroken.

## Interface
- N, 2, number of input channels (N >= 1)
- W, 32, payload width in bits
- SW, derived: max(1, $clog2(N)), width of channel index
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_data  input  N*W  channel payloads; channel i occupies bits [i*W +: W]
- in_valid  input  N  per-channel request/valid
- in_lock  input  N  per-channel lock request (used only with ARB_MUX_LOCK_EN)
- in_ready  output  N  per-channel accept; one-hot or zero
- out_data  output  W  registered selected payload
- out_valid  output  1  output register holds a beat
- out_ready  input  1  downstream accepts beat
- out_sel  output  SW  index of channel that supplied out_data

## Operation
- Single output register stage (out_data, out_sel, out_valid).
- load_en = !out_valid | out_ready.
- When load_en and any eligible in_valid is set, the arbiter grants one channel g.
  - in_ready[g] = 1 (combinational) and all other in_ready = 0.
  - The register captures in_data[g], sets out_sel = g, sets out_valid = 1.
  - The pointer is set to last = g.
- Round-robin: search starts at (last+1) mod N and wraps; the first valid channel wins.
- When load_en and no eligible request: out_valid <= 0; out_data and out_sel hold their old values.
- When !load_en: all in_ready = 0; out_data, out_sel and out_valid are held stable.
- A channel transfer occurs on in_valid[i] & in_ready[i]. An output transfer occurs on out_valid & out_ready.
- in_ready depends combinationally on in_valid and out_ready. Senders must not derive in_valid from in_ready.
- N = 1: the arbiter degenerates, out_sel is constant 0, and the block behaves as a 1-deep pipeline register.
- Reset (asynchronous, any time, including mid-transfer):
  - out_valid = 0, out_data = 0, out_sel = 0.
  - last = N-1, so channel 0 has first priority.
  - Lock is cleared.
  - The beat in flight is dropped.

## Timing
- Latency is 1 cycle: a beat accepted at edge k is visible on out_data/out_valid after edge k.
- Throughput is 1 beat/cycle with out_ready held high.
- Fairness: with all N channels continuously valid, grants rotate 0,1,...,N-1,0,... A waiting channel is served within N grants.
- Simultaneous output drain and input accept in one cycle is required; there is no bubble.
- out_ready low for any number of cycles loses no data and creates no duplicates.

## Configuration
- ARB_MUX_LOCK_EN defined:
  - A grant to channel g that transfers with in_lock[g] = 1 sets locked = 1, lock_ch = g.
  - While locked, only channel g is eligible. Other channels see in_ready = 0 even if g is idle.
  - A transfer from g with in_lock[g] = 0 clears the lock after that beat.
  - The round-robin pointer still advances to g.
- ARB_MUX_LOCK_EN undefined: in_lock is ignored, no lock state is built, and arbitration is always round-robin.

## Test plan
- Reset: assert rst mid-stream with out_valid = 1 -> out_valid, out_data and out_sel go to 0 immediately. After release with both channels valid, channel 0 is granted first.
- Round-robin, N = 4, W = 8: all in_valid = 4'hF, in_data = {8'h44,8'h33,8'h22,8'h11}, out_ready = 1 -> out_data sequence 11,22,33,44,11, out_sel 0,1,2,3,0, one beat per cycle.
- Backpressure: out_ready = 0 for 5 cycles while valid -> in_ready = 0 throughout and out_data stable. On out_ready = 1 the held beat drains and the next one loads in the same cycle.
- Sparse requests: only channel 2 valid for one cycle (data 8'hA5) -> one cycle later out_valid = 1, out_data = A5, out_sel = 2. The following cycle out_valid = 0.
- Lock (ARB_MUX_LOCK_EN, N = 2): ch0 sends 3 beats with in_lock = 1,1,0 while ch1 is constantly valid -> out_sel 0,0,0,1. in_ready[1] stays 0 until ch0's unlocked beat transfers.
- Lock disabled build: same stimulus -> out_sel alternates 0,1,0,1.
